// File: rtl/mac_seq_ctrl.sv
// Sequencer for the four-lane MAC array: clears the partial accumulators,
// counts operand beats, waits out the combiner pipeline and hands off the result.
module mac_seq_ctrl #(
   parameter int LEN_WIDTH = 8,
   parameter int PIPE_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [1:0]           job_cfg,
   input  logic [LEN_WIDTH-1:0] job_len,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic                 abort,
   output logic                 acc_clr,
   output logic                 acc_en,
   output logic [1:0]           comb_cfg,
   output logic                 comb_en,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 busy,
   output logic                 err_cfg
);

   localparam logic [1:0] MAC_SINGLE = 2'b00;
   localparam logic [1:0] MAC_ILLEGAL = 2'b11;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_ACCUM  = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;

   localparam int DW = 4;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT - 1);

   logic [2:0]           state_q, state_d;
   logic [LEN_WIDTH:0]   beat_q, beat_d;
   logic [LEN_WIDTH:0]   beat_inc;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [1:0]           cfg_q, cfg_d;
   logic                 err_q, err_d;
   logic                 live_q;
   logic                 accept;

   // live_q keeps job_ready low until the first edge after reset release
   assign job_ready = live_q & (state_q == S_IDLE);
   assign accept    = job_ready & job_valid;
   assign beat_inc  = beat_q + {{LEN_WIDTH{1'b0}}, 1'b1};

   assign acc_clr   = (state_q == S_CLEAR);
   assign op_ready  = (state_q == S_ACCUM);
   assign acc_en    = op_ready & op_valid;
   assign comb_en   = (state_q == S_DRAIN) | (state_q == S_OUTPUT);
   assign res_valid = (state_q == S_OUTPUT);
   assign busy      = (state_q != S_IDLE);
   assign comb_cfg  = cfg_q;
   assign err_cfg   = err_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      len_d   = len_q;
      drain_d = drain_q;
      cfg_d   = cfg_q;
      err_d   = 1'b0;
      if ((state_q != S_IDLE) && abort) begin
         state_d = S_IDLE;
         beat_d  = '0;
         drain_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_d = S_CLEAR;
                  len_d   = job_len;
                  err_d   = (job_cfg == MAC_ILLEGAL);
                  cfg_d   = (job_cfg == MAC_ILLEGAL) ? MAC_SINGLE : job_cfg;
               end
            end
            S_CLEAR: begin
               beat_d = '0;
               if (len_q != '0) begin
                  state_d = S_ACCUM;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
            S_ACCUM: begin
               if (op_valid) begin
                  beat_d = beat_inc;
                  if (beat_inc == {1'b0, len_q}) begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_LOAD;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q == '0) begin
                  state_d = S_OUTPUT;
               end else begin
                  drain_d = drain_q - DW'(1);
               end
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  state_d = S_IDLE;
                  beat_d  = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               beat_d  = '0;
               drain_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         len_q   <= '0;
         drain_q <= '0;
         cfg_q   <= MAC_SINGLE;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         drain_q <= drain_d;
         cfg_q   <= cfg_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

endmodule
